// File: rtl/gate_input_debounce_if.sv
// rtl/gate_input_debounce_if.sv - gate input debounce bundle: raw levels and enable in, debounced levels and edge pulses out
interface gate_input_debounce_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             en;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             busy;

    modport master (
        output din, en,
        input  dout, rise, fall, busy
    );

    modport slave (
        input  din, en,
        output dout, rise, fall, busy
    );
endinterface

// File: rtl/gate_input_debounce.sv
// rtl/gate_input_debounce.sv - per-channel synchronize-and-debounce of gate inputs
// DEBOUNCE_EDGE_EN: when defined, registered rise/fall pulses; otherwise rise/fall are tied to 0.
module gate_input_debounce #(
    parameter int WIDTH   = 4,
    parameter int STABLE  = 4,
    parameter int CNT_W   = 8,
    parameter bit RST_VAL = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    gate_input_debounce_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] dout_q;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] cnt_nz;
    logic [WIDTH-1:0] flip;

    // Synchronizer keeps sampling even while counting is frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= {WIDTH{RST_VAL}};
            sync2 <= {WIDTH{RST_VAL}};
        end else begin
            sync1 <= bus.din;
            sync2 <= sync1;
        end
    end

    // flip marks the edge on which a channel accepts its new level.
    always_comb begin
        flip   = '0;
        cnt_nz = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nz[i] = (cnt[i] != '0);
            flip[i]   = bus.en && (sync2[i] != dout_q[i]) && (cnt[i] == LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= {WIDTH{RST_VAL}};
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else if (bus.en) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (flip[i]) begin
                    dout_q[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else if (sync2[i] == dout_q[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= flip & sync2;
            fall_q <= flip & ~sync2;
        end
    end

    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
`else
    assign bus.rise = '0;
    assign bus.fall = '0;
`endif

    assign bus.dout = dout_q;
    assign bus.busy = |cnt_nz;

endmodule

// File: tb/tb_gate_input_debounce.sv
// tb/tb_gate_input_debounce.sv - directed and randomized checks of gate_input_debounce against a streak-count model
module tb_gate_input_debounce;

    localparam int W      = 4;
    localparam int STABLE = 4;
`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gate_input_debounce_if #(.WIDTH(W)) bus ();

    gate_input_debounce #(
        .WIDTH  (W),
        .STABLE (STABLE),
        .CNT_W  (8),
        .RST_VAL(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a level is accepted after STABLE consecutive enabled samples
    // (two edges late) that disagree with the current output.
    bit             m_s1 [W];
    bit             m_s2 [W];
    bit             m_out [W];
    int             m_streak [W];
    logic [W-1:0]   m_rise;
    logic [W-1:0]   m_fall;

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            m_s1[i] = 1'b0;
            m_s2[i] = 1'b0;
            m_out[i] = 1'b0;
            m_streak[i] = 0;
        end
        m_rise = '0;
        m_fall = '0;
    endtask

    task automatic model_step();
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < W; i++) begin
            if (bus.en) begin
                if (m_s2[i] != m_out[i]) begin
                    m_streak[i] = m_streak[i] + 1;
                    if (m_streak[i] == STABLE) begin
                        m_out[i] = m_s2[i];
                        m_streak[i] = 0;
                        m_rise[i] = m_out[i];
                        m_fall[i] = !m_out[i];
                    end
                end else begin
                    m_streak[i] = 0;
                end
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = bus.din[i];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin
        logic [W-1:0] e_dout;
        logic         e_busy;
        forever begin
            @(posedge clk);
            #2;
            if (chk_on) begin
                e_dout = '0;
                e_busy = 1'b0;
                for (int i = 0; i < W; i++) begin
                    e_dout[i] = m_out[i];
                    if (m_streak[i] != 0) e_busy = 1'b1;
                end
                check("cyc_dout", bus.dout, e_dout);
                check("cyc_busy", bus.busy, e_busy);
                check("cyc_rise", bus.rise, EDGE_EN ? m_rise : '0);
                check("cyc_fall", bus.fall, EDGE_EN ? m_fall : '0);
            end
        end
    end

    task automatic record(input int ch, output logic [15:0] d, output logic [15:0] r,
                          output logic [15:0] f, output logic [15:0] b);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            d[k] = bus.dout[ch];
            r[k] = bus.rise[ch];
            f[k] = bus.fall[ch];
            b[k] = bus.busy;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        bus.din = '0;
        bus.en  = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        logic [15:0] d, r, f, b;
        int          n;
        bit          found;

        bus.din = 4'hF;
        bus.en  = 1'b1;
        rst     = 1'b1;
        chk_on  = 1'b1;

        // Reset with all inputs high, then count edges to acceptance
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", bus.dout, 4'h0);
        check("rst_rise", bus.rise, 4'h0);
        check("rst_fall", bus.fall, 4'h0);
        check("rst_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        found = 1'b0;
        for (int k = 1; k <= 10 && !found; k++) begin
            @(posedge clk);
            #1;
            if (bus.dout == 4'hF) begin
                n = k;
                found = 1'b1;
            end
        end
        check("rst_latency", n, 6);
        check("rst_release_rise", bus.rise, EDGE_EN ? 4'hF : 4'h0);

        // Clean rise on channel 0
        settle();
        bus.din[0] = 1'b1;
        record(0, d, r, f, b);
        check("clean_dout", d, 16'hFFE0);
        check("clean_rise", r, EDGE_EN ? 16'h0020 : 16'h0000);
        check("clean_fall", f, 16'h0000);
        check("clean_busy", b, 16'h001C);

        // Three-cycle glitch on channel 1
        settle();
        bus.din[1] = 1'b1;
        fork
            record(1, d, r, f, b);
            begin
                repeat (3) @(negedge clk);
                bus.din[1] = 1'b0;
            end
        join
        check("glitch_dout", d, 16'h0000);
        check("glitch_rise", r, 16'h0000);
        check("glitch_busy", b, 16'h001C);

        // Enable dropped after two counted edges on channel 2
        settle();
        bus.din[2] = 1'b1;
        fork
            record(2, d, r, f, b);
            begin
                repeat (4) @(negedge clk);
                bus.en = 1'b0;
                repeat (5) @(negedge clk);
                bus.en = 1'b1;
            end
        join
        check("freeze_dout", d, 16'hFC00);
        check("freeze_busy", b, 16'h03FC);
        check("freeze_rise", r, EDGE_EN ? 16'h0400 : 16'h0000);

        // Reset while channel 3 has counted two samples
        settle();
        bus.din[3] = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_dout", bus.dout, 4'h0);
        check("midrst_pulses", {bus.rise, bus.fall}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        record(3, d, r, f, b);
        check("midrst_after_dout", d, 16'hFFE0);
        check("midrst_after_rise", r, EDGE_EN ? 16'h0020 : 16'h0000);
        check("midrst_after_fall", f, 16'h0000);
        check("midrst_after_busy", b, 16'h001C);

        // Randomized bouncing inputs, enable gaps and occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            for (int j = 0; j < W; j++) begin
                if ($urandom_range(7) == 0) bus.din[j] = ~bus.din[j];
            end
            bus.en = ($urandom_range(9) != 0);
            rst    = ($urandom_range(299) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gate_input_debounce.md
GATE_INPUT_DEBOUNCE -- requirements
Module: gate_input_debounce

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 4, number of independent input channels; one per gate input a,b,c,d.
- STABLE, 4, consecutive agreeing samples required to accept a new level; legal range 1..2^CNT_W-1.
- CNT_W, 8, width of each per-channel stability counter.
- RST_VAL, 0, level loaded into every channel's synchronizer and output at reset.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, reset; asynchronous, active-high.
- din, in, WIDTH, raw asynchronous levels; may bounce.
- en, in, 1, count enable; low freezes counters and outputs.
- dout, out, WIDTH, debounced registered levels; drive the downstream gate inputs.
- rise, out, WIDTH, one-cycle pulse per channel on dout 0->1.
- fall, out, WIDTH, one-cycle pulse per channel on dout 1->0.
- busy, out, 1, high while any channel counter is nonzero.

Function
REQ-003 Each channel SHALL pass din through a two-flop synchronizer; sync2 is the second stage.
- The synchronizer SHALL run regardless of en.

REQ-004 Per channel, on each edge with en=1:
- If sync2 != dout and cnt < STABLE-1: cnt increments.
- If sync2 != dout and cnt == STABLE-1: dout <= sync2 and cnt <= 0.
- If sync2 == dout: cnt <= 0.

REQ-005 Latency SHALL be exactly STABLE+2 rising edges from the first edge sampling a new, held din level to dout changing, with en high throughout.

REQ-006 Any reversion of sync2 to dout before STABLE agreeing samples SHALL clear cnt and leave dout unchanged.
- Glitches shorter than STABLE cycles are rejected.

REQ-007 With en=0, cnt and dout SHALL hold their values.
- Counting resumes from the held cnt when en returns high.

REQ-008 rise[i] and fall[i] SHALL be registered and asserted for exactly the one cycle in which dout[i] shows its new value; at most one of them is high per channel.

REQ-009 busy SHALL be the combinational OR over all channels of (cnt != 0).

REQ-010 Channels SHALL be fully independent.
- Simultaneous transitions on several channels each follow REQ-004 without interaction.

REQ-011 cnt SHALL never exceed STABLE-1, and no wrap-around is possible.

Reset
REQ-012 While rst=1, asynchronously:
- Synchronizer stages and dout SHALL equal {WIDTH{RST_VAL}}.
- All cnt SHALL equal 0.
- rise, fall and busy SHALL equal 0.

REQ-013 Reset asserted mid-count SHALL discard all partial counts.
- After release, a held din needs the full STABLE+2 edges per REQ-005.
- No rise/fall pulse SHALL be generated by reset entry or exit.

Configuration
REQ-014 Macro DEBOUNCE_EDGE_EN:
- Defined: the edge registers and the rise/fall behaviour of REQ-008 are present.
- Undefined: the edge registers are removed, and rise and fall are tied to constant 0 with the ports retained.
- In both cases, dout and busy are unchanged.

Verification (WIDTH=4, STABLE=4, RST_VAL=0, DEBOUNCE_EDGE_EN defined unless stated)
REQ-015 The bench SHALL cover these scenarios:
- Reset: rst=1 with din=4'hF for 3 cycles -> dout=4'h0, rise=fall=4'h0, busy=0; after release, dout=4'hF exactly 6 edges later.
- Clean rise: din[0] 0->1 held, en=1 -> dout[0]=1 on the 6th edge; rise[0] high for that single cycle; busy high on edges 3-5 only.
- Glitch: din[1] high for 3 cycles, then low -> dout[1] stays 0, rise[1] stays 0, busy returns to 0.
- Enable freeze: din[2] 0->1, en dropped after 2 counted edges for 5 cycles -> dout[2] holds 0 and busy stays 1; dout[2]=1 on the 2nd edge after en returns.
- Reset mid-count: rst pulsed while cnt[3]=2 -> cnt cleared, dout[3]=0, no pulses; after release, dout[3]=1 after 6 edges.
- Macro undefined, clean rise repeated -> dout[0] timing identical; rise=fall=4'h0 throughout.
